stream_lane_permuter: RTL and testbench
=======================================

Name: stream_lane_permuter

Overview:
- Parametrised successor to the fixed byte-swap stream core.
- Sits between the AXI read master's AXI4-Stream output and the write master's input.
- Permutes bytes and words of each beat according to a runtime-selectable mode, latched per packet.
- Carries tkeep and tlast through the same permutation, runs at full throughput with a 2-entry skid buffer, and exposes beat/packet statistics.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, stream data width in bits; must be a multiple of C_WORD_BIT_WIDTH.
- C_WORD_BIT_WIDTH, 32, word size for modes 1/2; must be a multiple of C_BYTE_BIT_WIDTH.
- C_BYTE_BIT_WIDTH, 8, byte size; tkeep has one bit per byte.
- C_CNT_WIDTH, 32, width of the statistics counters.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- cfg_mode  in  2  permutation mode: 0 pass, 1 byte-reverse within each word, 2 word-reverse across bus, 3 full-bus byte-reverse.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  input data.
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/C_BYTE_BIT_WIDTH  input byte enables.
- s_axis_tlast  in  1  end of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  permuted data.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/C_BYTE_BIT_WIDTH  permuted byte enables.
- m_axis_tlast  out  1  end of packet (not permuted).
- busy  out  1  high while mid-packet or while the buffer holds data.
- stat_beats  out  C_CNT_WIDTH  count of beats accepted on s_axis.
- stat_pkts  out  C_CNT_WIDTH  count of tlast beats emitted on m_axis.

Behaviour:
- Reset (areset=1 sampled on edge):
  - s_axis_tready=0 during reset, then 1 on the first cycle after reset.
  - m_axis_tvalid=0; m_axis_tdata/tkeep/tlast=0.
  - busy=0; stat_beats=0; stat_pkts=0.
  - Skid buffer emptied; in_pkt=0; latched mode=0.
  - Reset mid-packet discards all held beats; no partial output after reset.
- Mode latch:
  - On any accepted beat (tvalid&tready) with in_pkt=0, cfg_mode is used for that beat and stored as pkt_mode.
  - Subsequent beats of the same packet use pkt_mode; cfg_mode changes mid-packet are ignored.
  - in_pkt set on an accepted non-last beat; cleared on an accepted tlast beat.
  - A single-beat packet uses cfg_mode and leaves in_pkt=0.
- Permutation (combinational on input, applied before buffering). Let B = bytes per bus, W = bytes per word.
  - Mode 0: out byte i = in byte i.
  - Mode 1: within word k, out byte k*W+j = in byte k*W+(W-1-j).
  - Mode 2: out word k = in word (N-1-k), where N = words per bus; byte order inside each word is kept.
  - Mode 3: out byte i = in byte (B-1-i).
  - tkeep bit i follows byte i under the same map.
- Buffer: 2-entry skid (main output register plus skid register).
  - Latency 1 cycle from input acceptance to m_axis_tvalid when empty.
  - s_axis_tready is registered and equals "skid entry empty".
  - Sustains 1 beat/cycle with m_axis_tready held high.
  - Output stalled with the buffer full: s_axis_tready drops the next cycle; no beat is lost or duplicated.
  - Simultaneous input accept and output pop keep occupancy unchanged.
  - m_axis_tdata/tkeep/tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- Statistics:
  - stat_beats increments on each s_axis acceptance.
  - stat_pkts increments on each m_axis handshake with tlast=1.
  - Both wrap modulo 2^C_CNT_WIDTH.
- busy = in_pkt | m_axis_tvalid | skid_full.
- Elaboration error if the width divisibility rules are violated.

Test Plan:
All scenarios use C_AXIS_TDATA_WIDTH=64 and C_WORD_BIT_WIDTH=32.
1. Modes on one-beat packets, tdata=0x0011223344556677, tkeep=0x0F, tlast=1, m_axis_tready=1:
   - mode0 -> 0x0011223344556677 / keep 0x0F.
   - mode1 -> 0x3322110077665544 / 0x0F.
   - mode2 -> 0x4455667700112233 / 0xF0.
   - mode3 -> 0x7766554433221100 / 0xF0.
   - Output 1 cycle after accept each time; stat_pkts=4.
2. Mode latch: 3-beat packet started with cfg_mode=1, cfg_mode switched to 2 before beat 2 -> all 3 beats byte-reversed per word; next packet uses mode 2.
3. Backpressure: 8 back-to-back beats, m_axis_tready low for cycles 2-5 -> s_axis_tready falls after 2 beats are held; output order and values intact, no duplicates; stat_beats=8.
4. Throughput: 100 beats with both sides always ready -> 100 output beats in 101 cycles; busy drops 1 cycle after the last tlast pop.
5. Reset mid-packet: assert areset after beat 2 of 4 with output stalled -> next cycle m_axis_tvalid=0, counters 0, busy=0; a new packet then latches a fresh cfg_mode.
6. Counter wrap, C_CNT_WIDTH=4: 17 single-beat packets -> stat_beats=1, stat_pkts=1.

Source files
------------

// File: rtl/stream_lane_permuter.sv
// AXI4-Stream byte/word lane permuter with per-packet mode latch, 2-entry skid buffer
// and beat/packet statistics.
module stream_lane_permuter #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_WORD_BIT_WIDTH   = 32,
  parameter int C_BYTE_BIT_WIDTH   = 8,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                                             aclk,
  input  logic                                             areset,
  input  logic [1:0]                                       cfg_mode,
  input  logic                                             s_axis_tvalid,
  output logic                                             s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]                    s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/C_BYTE_BIT_WIDTH-1:0]   s_axis_tkeep,
  input  logic                                             s_axis_tlast,
  output logic                                             m_axis_tvalid,
  input  logic                                             m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                    m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/C_BYTE_BIT_WIDTH-1:0]   m_axis_tkeep,
  output logic                                             m_axis_tlast,
  output logic                                             busy,
  output logic [C_CNT_WIDTH-1:0]                           stat_beats,
  output logic [C_CNT_WIDTH-1:0]                           stat_pkts
);

  localparam int BusBytes  = C_AXIS_TDATA_WIDTH / C_BYTE_BIT_WIDTH;
  localparam int WordBytes = C_WORD_BIT_WIDTH / C_BYTE_BIT_WIDTH;
  localparam int BusWords  = C_AXIS_TDATA_WIDTH / C_WORD_BIT_WIDTH;
  localparam int EntryBits = C_AXIS_TDATA_WIDTH + BusBytes + 1;

  if ((C_AXIS_TDATA_WIDTH % C_WORD_BIT_WIDTH) != 0) begin : g_badBusWidth
    $error("C_AXIS_TDATA_WIDTH must be a multiple of C_WORD_BIT_WIDTH");
  end
  if ((C_WORD_BIT_WIDTH % C_BYTE_BIT_WIDTH) != 0) begin : g_badWordWidth
    $error("C_WORD_BIT_WIDTH must be a multiple of C_BYTE_BIT_WIDTH");
  end

  // Source byte lane feeding output byte lane i for the given mode.
  function automatic int srcIndex(input logic [1:0] mode, input int i);
    int k;
    int j;
    k = i / WordBytes;
    j = i % WordBytes;
    case (mode)
      2'd1:    srcIndex = k * WordBytes + (WordBytes - 1 - j);
      2'd2:    srcIndex = (BusWords - 1 - k) * WordBytes + j;
      2'd3:    srcIndex = BusBytes - 1 - i;
      default: srcIndex = i;
    endcase
  endfunction

  logic                          r_inPkt;
  logic [1:0]                    r_pktMode;
  logic                          r_sReady;
  logic                          r_mValid;
  logic [EntryBits-1:0]          r_main;
  logic                          r_skValid;
  logic [EntryBits-1:0]          r_skid;
  logic [C_CNT_WIDTH-1:0]        r_statBeats;
  logic [C_CNT_WIDTH-1:0]        r_statPkts;

  logic [1:0]                    w_mode;
  logic [C_AXIS_TDATA_WIDTH-1:0] w_permData;
  logic [BusBytes-1:0]           w_permKeep;
  logic [EntryBits-1:0]          w_inEntry;
  logic                          w_accept;
  logic                          w_pop;
  logic                          w_mLoad;
  logic                          w_skLoad;
  logic                          w_skValidNext;
  logic                          w_mLast;

  assign w_mode    = r_inPkt ? r_pktMode : cfg_mode;
  assign w_accept  = s_axis_tvalid & r_sReady;
  assign w_mLast   = r_main[EntryBits-1];
  assign w_pop     = r_mValid & m_axis_tready;
  assign w_mLoad   = ~r_mValid | m_axis_tready;
  assign w_skLoad  = w_accept & ~w_mLoad;
  assign w_inEntry = {s_axis_tlast, w_permKeep, w_permData};

  always_comb begin
    w_permData = '0;
    w_permKeep = '0;
    for (int i = 0; i < BusBytes; i++) begin
      w_permData[i*C_BYTE_BIT_WIDTH +: C_BYTE_BIT_WIDTH] =
        s_axis_tdata[srcIndex(w_mode, i)*C_BYTE_BIT_WIDTH +: C_BYTE_BIT_WIDTH];
      w_permKeep[i] = s_axis_tkeep[srcIndex(w_mode, i)];
    end
  end

  // The skid entry is never filled and drained in the same cycle: tready is low while it is full.
  always_comb begin
    w_skValidNext = r_skValid;
    if (w_mLoad) begin
      w_skValidNext = 1'b0;
    end else if (w_accept) begin
      w_skValidNext = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_mValid  <= 1'b0;
      r_main    <= '0;
      r_skValid <= 1'b0;
      r_skid    <= '0;
      r_sReady  <= 1'b0;
    end else begin
      if (w_mLoad) begin
        if (r_skValid) begin
          r_main   <= r_skid;
          r_mValid <= 1'b1;
        end else begin
          r_mValid <= w_accept;
          if (w_accept) begin
            r_main <= w_inEntry;
          end
        end
      end
      if (w_skLoad) begin
        r_skid <= w_inEntry;
      end
      r_skValid <= w_skValidNext;
      r_sReady  <= ~w_skValidNext;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_inPkt   <= 1'b0;
      r_pktMode <= 2'd0;
    end else if (w_accept) begin
      if (!r_inPkt) begin
        r_pktMode <= cfg_mode;
      end
      r_inPkt <= ~s_axis_tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_statBeats <= '0;
      r_statPkts  <= '0;
    end else begin
      if (w_accept) begin
        r_statBeats <= r_statBeats + C_CNT_WIDTH'(1);
      end
      if (w_pop && w_mLast) begin
        r_statPkts <= r_statPkts + C_CNT_WIDTH'(1);
      end
    end
  end

  assign s_axis_tready = r_sReady;
  assign m_axis_tvalid = r_mValid;
  assign m_axis_tdata  = r_main[C_AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tkeep  = r_main[C_AXIS_TDATA_WIDTH +: BusBytes];
  assign m_axis_tlast  = w_mLast;
  assign busy          = r_inPkt | r_mValid | r_skValid;
  assign stat_beats    = r_statBeats;
  assign stat_pkts     = r_statPkts;

endmodule

// File: tb/tb_stream_lane_permuter.sv
// Randomised scoreboard bench for stream_lane_permuter (64-bit bus, 32-bit words, 4-bit counters).
module tb_stream_lane_permuter;

  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [1:0]    cfg_mode;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          busy;
  logic [CW-1:0] stat_beats;
  logic [CW-1:0] stat_pkts;

  always #5 aclk = ~aclk;

  stream_lane_permuter #(
    .C_AXIS_TDATA_WIDTH(64),
    .C_WORD_BIT_WIDTH(32),
    .C_BYTE_BIT_WIDTH(8),
    .C_CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_mode(cfg_mode),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy),
    .stat_beats(stat_beats),
    .stat_pkts(stat_pkts)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       expQ[$];
  bit          mInPkt;
  logic [1:0]  mPktMode;
  int unsigned beatCnt;
  int unsigned pktCnt;
  int unsigned popTotal;
  int          errors;
  int          checks;

  // Reference permutation expressed with streaming operators on whole words / the whole bus.
  function automatic void permute(input logic [1:0] mode, input logic [63:0] d, input logic [7:0] k,
                                  output logic [63:0] od, output logic [7:0] okeep);
    logic [31:0] w;
    logic [31:0] wr;
    logic [3:0]  n;
    logic [3:0]  nr;
    od    = d;
    okeep = k;
    case (mode)
      2'd1: begin
        for (int x = 0; x < 2; x++) begin
          w  = d[x*32 +: 32];
          wr = {<<8{w}};
          od[x*32 +: 32] = wr;
          n  = k[x*4 +: 4];
          nr = {<<{n}};
          okeep[x*4 +: 4] = nr;
        end
      end
      2'd2: begin
        od    = {<<32{d}};
        okeep = {<<4{k}};
      end
      2'd3: begin
        od    = {<<8{d}};
        okeep = {<<{k}};
      end
      default: ;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive at negedge, check state, score handshakes, then cross the posedge.
  task automatic applyStimulus(input bit v, input logic [63:0] d, input logic [7:0] k, input bit l,
                               input logic [1:0] m, input bit rdy, output bit acc);
    beat_t      e;
    beat_t      f;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic [1:0]  em;
    bit          pop;
    @(negedge aclk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    cfg_mode      = m;
    m_axis_tready = rdy;
    checkOutput("s_tready", 64'(s_axis_tready), 64'(expQ.size() < 2));
    checkOutput("m_tvalid", 64'(m_axis_tvalid), 64'(expQ.size() > 0));
    checkOutput("busy", 64'(busy), 64'(mInPkt || (expQ.size() > 0)));
    checkOutput("stat_beats", 64'(stat_beats), 64'(beatCnt % 16));
    checkOutput("stat_pkts", 64'(stat_pkts), 64'(pktCnt % 16));
    acc = v && s_axis_tready;
    pop = m_axis_tvalid && rdy;
    if (pop) begin
      if (expQ.size() == 0) begin
        checkOutput("extra_beat", 64'(m_axis_tvalid), 64'd0);
      end else begin
        f = expQ.pop_front();
        checkOutput("m_tdata", m_axis_tdata, f.data);
        checkOutput("m_tkeep", 64'(m_axis_tkeep), 64'(f.keep));
        checkOutput("m_tlast", 64'(m_axis_tlast), 64'(f.last));
        if (f.last) pktCnt++;
        popTotal++;
      end
    end
    if (acc) begin
      em = mInPkt ? mPktMode : m;
      if (!mInPkt) mPktMode = m;
      permute(em, d, k, pd, pk);
      e.data = pd;
      e.keep = pk;
      e.last = l;
      expQ.push_back(e);
      mInPkt = !l;
      beatCnt++;
    end
    @(posedge aclk);
  endtask

  task automatic applyReset();
    @(negedge aclk);
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_m_tdata", m_axis_tdata, 64'd0);
    checkOutput("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    checkOutput("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_beats", 64'(stat_beats), 64'd0);
    checkOutput("rst_pkts", 64'(stat_pkts), 64'd0);
    checkOutput("rst_tready", 64'(s_axis_tready), 64'd0);
    areset = 1'b0;
    expQ.delete();
    mInPkt   = 1'b0;
    mPktMode = 2'd0;
    beatCnt  = 0;
    pktCnt   = 0;
    @(posedge aclk);
  endtask

  task automatic drainOut();
    bit a;
    int n = 0;
    while (expQ.size() > 0 && n < 50) begin
      applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b1, a);
      n++;
    end
    checkOutput("drain_left", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] pattern;
    logic [63:0] s1Data [4];
    logic [7:0]  s1Keep [4];
    bit          a;
    int          idx;
    int          cyc;
    int unsigned startPops;

    errors = 0;
    checks = 0;
    popTotal = 0;
    areset = 1'b1;
    cfg_mode = 2'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    pattern = 64'h0011223344556677;
    s1Data = '{64'h0011223344556677, 64'h3322110077665544, 64'h4455667700112233, 64'h7766554433221100};
    s1Keep = '{8'h0F, 8'h0F, 8'hF0, 8'hF0};

    applyReset();

    // Every mode on single-beat packets, output visible one cycle after acceptance.
    for (int m = 0; m < 4; m++) begin
      applyStimulus(1'b1, pattern, 8'h0F, 1'b1, 2'(m), 1'b1, a);
      checkOutput("s1_accept", 64'(a), 64'd1);
      #1;
      checkOutput("s1_valid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("s1_data", m_axis_tdata, s1Data[m]);
      checkOutput("s1_keep", 64'(m_axis_tkeep), 64'(s1Keep[m]));
    end
    drainOut();
    #1;
    checkOutput("s1_pkts", 64'(stat_pkts), 64'd4);

    // Mode change mid-packet is ignored; the next packet picks it up.
    applyStimulus(1'b1, pattern, 8'hFF, 1'b0, 2'd1, 1'b1, a);
    applyStimulus(1'b1, pattern, 8'hFF, 1'b0, 2'd2, 1'b1, a);
    applyStimulus(1'b1, pattern, 8'hFF, 1'b1, 2'd2, 1'b1, a);
    #1;
    checkOutput("s2_latched", m_axis_tdata, 64'h3322110077665544);
    applyStimulus(1'b1, pattern, 8'hFF, 1'b1, 2'd2, 1'b1, a);
    #1;
    checkOutput("s2_next_pkt", m_axis_tdata, 64'h4455667700112233);
    drainOut();

    // Backpressure: output stalled for cycles 2-5 of an 8-beat burst.
    applyReset();
    idx = 0;
    for (int c = 1; c <= 40 && (idx < 8 || expQ.size() > 0); c++) begin
      applyStimulus(idx < 8, {$urandom, $urandom}, 8'($urandom), idx == 7, 2'($urandom),
                    !(c >= 2 && c <= 5), a);
      if (a) idx++;
    end
    #1;
    checkOutput("s3_beats", 64'(stat_beats), 64'd8);
    checkOutput("s3_pkts", 64'(stat_pkts), 64'd1);

    // Throughput: 100 beats in packets of 10 with both sides always ready.
    startPops = popTotal;
    idx = 0;
    cyc = 0;
    while ((popTotal - startPops) < 100 && cyc < 300) begin
      cyc++;
      applyStimulus(idx < 100, {$urandom, $urandom}, 8'($urandom), (idx % 10) == 9, 2'($urandom),
                    1'b1, a);
      if (a) idx++;
    end
    checkOutput("s4_cycles", 64'(cyc), 64'd101);
    #1;
    checkOutput("s4_busy", 64'(busy), 64'd0);

    // Reset in the middle of a stalled packet, then a fresh packet latches a new mode.
    applyReset();
    applyStimulus(1'b1, pattern, 8'hFF, 1'b0, 2'd3, 1'b0, a);
    applyStimulus(1'b1, pattern, 8'hFF, 1'b0, 2'd3, 1'b0, a);
    applyReset();
    applyStimulus(1'b1, pattern, 8'hFF, 1'b0, 2'd1, 1'b1, a);
    #1;
    checkOutput("s5_fresh_mode", m_axis_tdata, 64'h3322110077665544);
    applyStimulus(1'b1, pattern, 8'hFF, 1'b1, 2'd3, 1'b1, a);
    drainOut();

    // Counter wrap with 4-bit statistics.
    applyReset();
    for (int p = 0; p < 17; p++) begin
      applyStimulus(1'b1, {$urandom, $urandom}, 8'($urandom), 1'b1, 2'($urandom), 1'b1, a);
    end
    drainOut();
    #1;
    checkOutput("s6_beats_wrap", 64'(stat_beats), 64'd1);
    checkOutput("s6_pkts_wrap", 64'(stat_pkts), 64'd1);

    // Random traffic with random backpressure.
    for (int r = 0; r < 400; r++) begin
      applyStimulus($urandom_range(0, 3) != 0, {$urandom, $urandom}, 8'($urandom),
                    $urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 2) != 0, a);
    end
    drainOut();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
